// File: rtl/tk_pkg.sv
// Shared definitions for the inverse tweakey schedule: permutation table,
// inverse lane LFSRs, FSM state type and a word-select helper.
package tk_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_UNROLL,
    ST_DRAIN
  } tk_state_t;

  // Forward tweakey permutation P; the inverse round writes old[P[i]] = new[i]
  localparam int unsigned PT_INV [16] = '{9, 15, 8, 13, 10, 14, 12, 11,
                                          0, 1, 2, 3, 4, 5, 6, 7};

  function automatic logic [7:0] lfsr2_inv(input logic [7:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

  function automatic logic [7:0] lfsr3_inv(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

  // Word k carries bytes 4k..4k+3, byte 0 in the top bits of the lane
  function automatic logic [31:0] tk_word(input logic [127:0] t, input logic [1:0] k);
    case (k)
      2'd0:    return t[127:96];
      2'd1:    return t[95:64];
      2'd2:    return t[63:32];
      default: return t[31:0];
    endcase
  endfunction

endpackage

// File: rtl/tk_inv_round.sv
// One inverse tweakey round: undo the lane LFSR on bytes 0..7, then undo
// the byte permutation. Purely combinational.
module tk_inv_round
  import tk_pkg::*;
#(
  parameter int unsigned LANE = 2
) (
  input  logic [127:0] tk_in,
  output logic [127:0] tk_out
);

  logic [7:0] b_in [16];
  logic [7:0] b_lf [16];

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign b_in[i] = tk_in[127-8*i -: 8];
    if (i < 8) begin : g_lfsr
      assign b_lf[i] = (LANE == 2) ? lfsr2_inv(b_in[i]) :
                       (LANE == 3) ? lfsr3_inv(b_in[i]) : b_in[i];
    end else begin : g_pass
      assign b_lf[i] = b_in[i];
    end
    assign tk_out[127-8*PT_INV[i] -: 8] = b_lf[i];
  end

endmodule

// File: rtl/tk_unroll_32b.sv
// Rewinds one tweakey lane by ROUNDS rounds: loads 4 words, applies UNROLL
// inverse rounds per clock, then streams the restored lane back out.
module tk_unroll_32b
  import tk_pkg::*;
#(
  parameter int unsigned ROUNDS = 56,
  parameter int unsigned LANE   = 2,
  parameter int unsigned UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam logic [5:0] R_STEP = 6'(UNROLL);
  localparam logic [5:0] R_LAST = 6'(ROUNDS - UNROLL);

  tk_state_t    state;
  logic [1:0]   wcnt;
  logic [5:0]   rcnt;
  logic [127:0] tk;
  logic [127:0] chain [UNROLL+1];

  assign chain[0] = tk;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    tk_inv_round #(.LANE(LANE)) u_round (
      .tk_in  (chain[g]),
      .tk_out (chain[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      wcnt      <= '0;
      rcnt      <= '0;
      tk        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            case (wcnt)
              2'd0:    tk[127:96] <= in_data;
              2'd1:    tk[95:64]  <= in_data;
              2'd2:    tk[63:32]  <= in_data;
              default: tk[31:0]   <= in_data;
            endcase
            wcnt <= wcnt + 2'd1;
            if (wcnt == 2'd3) begin
              state    <= ST_UNROLL;
              rcnt     <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        ST_UNROLL: begin
          tk   <= chain[UNROLL];
          rcnt <= rcnt + R_STEP;
          // out_data is registered, so word 0 is taken straight from the chain
          if (rcnt == R_LAST) begin
            state     <= ST_DRAIN;
            wcnt      <= '0;
            out_valid <= 1'b1;
            out_data  <= chain[UNROLL][127:96];
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            wcnt     <= wcnt + 2'd1;
            out_data <= tk_word(tk, 2'(wcnt + 2'd1));
            if (wcnt == 2'd3) begin
              state     <= ST_LOAD;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_tk_unroll_32b.sv
// Bench for tk_unroll_32b: forward-schedule reference model, per-cycle
// handshake/data compare on six parameterisations, plus directed checks.
module tb_tk_unroll_32b;

  localparam int NI = 6;
  localparam int unsigned P_LANE   [NI] = '{1, 2, 2, 2, 2, 3};
  localparam int unsigned P_ROUNDS [NI] = '{16, 1, 56, 56, 56, 56};
  localparam int unsigned P_UNR    [NI] = '{1, 1, 1, 2, 4, 1};
  localparam int unsigned PERM [16] = '{9, 15, 8, 13, 10, 14, 12, 11,
                                        0, 1, 2, 3, 4, 5, 6, 7};

  logic        clk;
  logic        rst       [NI];
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [31:0] in_data   [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [31:0] out_data  [NI];
  logic        busy      [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 load, 1 compute, 2 drain
  int           m_ph   [NI];
  int           m_cnt  [NI];
  int           m_w    [NI];
  logic [127:0] m_lane [NI];
  logic [127:0] m_exp  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    tk_unroll_32b #(
      .ROUNDS (P_ROUNDS[g]),
      .LANE   (P_LANE[g]),
      .UNROLL (P_UNR[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Forward SKINNY tweakey schedule: permute bytes, then lane LFSR on bytes 0..7
  function automatic logic [127:0] fwd(input logic [127:0] l, input int unsigned lane,
                                       input int unsigned rounds);
    logic [7:0]   b [16];
    logic [7:0]   n [16];
    logic [127:0] r;
    for (int unsigned i = 0; i < 16; i++) b[i] = 8'(l >> (8 * (15 - i)));
    for (int unsigned k = 0; k < rounds; k++) begin
      for (int unsigned i = 0; i < 16; i++) n[i] = b[PERM[i]];
      for (int unsigned i = 0; i < 8; i++) begin
        if (lane == 2) n[i] = {n[i][6:0], n[i][7] ^ n[i][5]};
        else if (lane == 3) n[i] = {n[i][0] ^ n[i][6], n[i][7:1]};
      end
      b = n;
    end
    r = '0;
    for (int unsigned i = 0; i < 16; i++) r = (r << 8) | 128'(b[i]);
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] l, input int k);
    return 32'(l >> (32 * (3 - k)));
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst[g]) begin
        m_ph[g] <= 0;
        m_w[g]  <= 0;
      end else begin
        case (m_ph[g])
          0: if (in_valid[g]) begin
            if (m_w[g] == 3) begin
              m_ph[g]   <= 1;
              m_w[g]    <= 0;
              m_cnt[g]  <= int'(P_ROUNDS[g] / P_UNR[g]);
              m_lane[g] <= m_exp[g];
            end else m_w[g] <= m_w[g] + 1;
          end
          1: begin
            if (m_cnt[g] == 1) m_ph[g] <= 2;
            m_cnt[g] <= m_cnt[g] - 1;
          end
          default: if (out_ready[g]) begin
            if (m_w[g] == 3) begin
              m_ph[g] <= 0;
              m_w[g]  <= 0;
            end else m_w[g] <= m_w[g] + 1;
          end
        endcase
      end
    end
  end

  task automatic chk(input string nm, input int g, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h want %0h", nm, g, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        chk("in_ready", g, 128'(in_ready[g]), 128'(m_ph[g] == 0));
        chk("out_valid", g, 128'(out_valid[g]), 128'(m_ph[g] == 2));
        chk("busy", g, 128'(busy[g]), 128'(m_ph[g] != 0));
        if (m_ph[g] == 2) chk("out_data", g, 128'(out_data[g]), 128'(word_of(m_lane[g], m_w[g])));
      end
    end
  endtask

  task automatic load(input int g, input logic [127:0] din);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid[g] = 1'b1;
      in_data[g]  = word_of(din, k);
    end
    @(negedge clk);
    in_valid[g] = 1'b0;
  endtask

  // Load, then measure first-out_valid latency and busy duration (bounded)
  task automatic run(input int g, input logic [127:0] din, input logic [127:0] exp,
                     input int lat_exp, input int busy_exp);
    int n;
    int lat;
    m_exp[g] = exp;
    load(g, din);
    n   = 0;
    lat = -1;
    while (busy[g] && n < 400) begin
      if (out_valid[g] && lat < 0) lat = n + 1;
      @(negedge clk);
      n++;
    end
    chk("latency", g, 128'(lat), 128'(lat_exp));
    chk("busy_cycles", g, 128'(n), 128'(busy_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [127:0] l0;
    logic [127:0] l1;
    int lat_tab [3];
    int n;
    lat_tab = '{57, 29, 15};
    for (int g = 0; g < NI; g++) begin
      rst[g]       = 1'b1;
      in_valid[g]  = 1'b0;
      in_data[g]   = '0;
      out_ready[g] = 1'b1;
      m_exp[g]     = '0;
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_in_ready", g, 128'(in_ready[g]), 128'(1'b1));
      chk("rst_out_valid", g, 128'(out_valid[g]), 128'(1'b0));
      chk("rst_busy", g, 128'(busy[g]), 128'(1'b0));
      chk("rst_out_data", g, 128'(out_data[g]), 128'(32'h0));
      rst[g] = 1'b0;
    end
    fork
      compare_loop();
    join_none

    // Hand-computed pins for the reference model
    chk("model_tk2", 0, fwd(128'h00000000_00000000_00010000_00000000, 2, 1),
        128'h02000000_00000000_00000000_00000000);
    chk("model_tk3", 0, fwd(128'h00000000_00000000_00010000_00000000, 3, 1),
        128'h80000000_00000000_00000000_00000000);
    chk("model_tk1_order16", 0, fwd(128'h00010203_04050607_08090A0B_0C0D0E0F, 1, 16),
        128'h00010203_04050607_08090A0B_0C0D0E0F);

    run(0, 128'h00010203_04050607_08090A0B_0C0D0E0F,
        128'h00010203_04050607_08090A0B_0C0D0E0F, 17, 20);
    run(1, 128'h02000000_00000000_00000000_00000000,
        128'h00000000_00000000_00010000_00000000, 2, 5);

    for (int g = 2; g < 5; g++) begin
      for (int rep = 0; rep < 2; rep++) begin
        l0 = {$urandom, $urandom, $urandom, $urandom};
        run(g, fwd(l0, 2, 56), l0, lat_tab[g-2], lat_tab[g-2] + 3);
      end
    end

    // Backpressure at word 2, with in_valid driven through compute and drain
    l0 = {$urandom, $urandom, $urandom, $urandom};
    m_exp[2] = l0;
    load(2, fwd(l0, 2, 56));
    in_valid[2] = 1'b1;
    in_data[2]  = 32'hDEADBEEF;
    n = 0;
    while (!out_valid[2] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", 2, 128'(n + 1), 128'(57));
    repeat (2) @(negedge clk);
    out_ready[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold", 2, 128'(out_data[2]), 128'(l0[63:32]));
      chk("bp_in_ready", 2, 128'(in_ready[2]), 128'(1'b0));
    end
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    n = 0;
    while (busy[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_drain_cycles", 2, 128'(n), 128'(2));

    // Reset while rcnt = 20, then a fresh load
    l0 = {$urandom, $urandom, $urandom, $urandom};
    m_exp[2] = l0;
    load(2, fwd(l0, 2, 56));
    repeat (20) @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    chk("mid_rst_in_ready", 2, 128'(in_ready[2]), 128'(1'b1));
    chk("mid_rst_out_valid", 2, 128'(out_valid[2]), 128'(1'b0));
    chk("mid_rst_busy", 2, 128'(busy[2]), 128'(1'b0));
    chk("mid_rst_out_data", 2, 128'(out_data[2]), 128'(32'h0));
    l1 = {$urandom, $urandom, $urandom, $urandom};
    run(2, fwd(l1, 2, 56), l1, 57, 60);

    run(5, '0, '0, 57, 60);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tk_unroll_32b.md
Name: tk_unroll_32b

Overview:
- Reverse-direction companion to the per-round tweakey state register.
- After a SKINNY-128-384 encryption, accepts the final 128-bit tweakey lane over a 32-bit bus.
- Runs the tweakey schedule backwards for ROUNDS rounds and streams the restored initial lane out on a 32-bit bus.
- Feeds the revert input of the tweakey registers, so the next Romulus-N block does not need to reload the key.

Parameters:
- ROUNDS, 56: number of inverse rounds to apply. Range 1..63.
- LANE, 2: tweakey lane. 1 = TK1 (no LFSR), 2 = TK2, 3 = TK3.
- UNROLL, 1: inverse rounds per clock. Must divide ROUNDS; allowed values 1, 2, 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a valid word.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  32  tweakey word. Word k carries bytes 4k..4k+3; byte 4k sits in [31:24].
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  32  restored tweakey word, same byte order as in_data.
- busy  out  1  high in any state other than LOAD.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state LOAD, word counter 0, round counter 0, 128-bit state 0, in_ready=1, out_valid=0, out_data=0, busy=0.
- Transfer rule: a beat transfers when valid && ready on the same edge. Source and sink hold their data stable while valid is high and ready is low.
- LOAD state:
  - in_ready=1.
  - Each accepted word is written to state word[wcnt], then wcnt increments.
  - The 4th accepted word moves the FSM to UNROLL, resets rcnt to 0 and drops in_ready the next cycle.
- UNROLL state (per cycle, UNROLL iterations):
  - Step a, inverse LFSR on bytes 0..7 only:
    - LANE=2: (x7..x0) -> (x0^x6, x7..x1).
    - LANE=3: (x7..x0) -> (x6..x0, x7^x5).
    - LANE=1: no change.
  - Step b, inverse permutation: old[P[i]] = new[i], with P = {9,15,8,13,10,14,12,11,0,1,2,3,4,5,6,7}.
  - rcnt increments by UNROLL each cycle.
  - When rcnt+UNROLL == ROUNDS, move to DRAIN with wcnt=0. Compute latency is exactly ROUNDS/UNROLL cycles.
- DRAIN state:
  - out_valid=1, out_data = state word[wcnt].
  - wcnt advances only on an accepted beat.
  - After the 4th accepted beat, move to LOAD; out_valid=0 and in_ready=1 the next cycle.
- End-to-end latency: from the 4th input beat to the first out_valid is ROUNDS/UNROLL + 1 cycles.
- in_valid is ignored in UNROLL and DRAIN; no input word is lost or absorbed there.
- Backpressure: out_ready low in DRAIN holds out_data unchanged indefinitely.
- Counters: wcnt is 2 bits and wraps naturally after 3. rcnt is 6 bits; reaching the terminal count is the only exit from UNROLL.
- Reset mid-operation: rst in any state returns to the full reset values on the same edge. Partial loads and outputs are discarded.
- Simultaneous events: in LOAD, rst wins over an accepted beat.

Decomposition:
- Shared package (tk_pkg) holds:
  - PT_INV byte-index constant array.
  - Inverse LFSR functions for TK2 and TK3.
  - State enum {LOAD, UNROLL, DRAIN}.
- One combinational sub-module, tk_inv_round. Ports: tk_in[127:0], tk_out[127:0]; parameter LANE. It implements one inverse round.
- The top instantiates a chain of UNROLL copies of tk_inv_round, plus the FSM, counters and state register.

Test Plan:
- LANE=1, ROUNDS=16, input 00010203_04050607_08090A0B_0C0D0E0F -> output identical to the input (P_T has order 16). Latency 17 cycles.
- LANE=2, ROUNDS=1, input byte0=0x02, all other bytes 0 -> output byte9=0x01, all other bytes 0. out_data words 00000000, 00000000, 00010000, 00000000.
- LANE=2, ROUNDS=56: feed random lanes produced by a forward-schedule reference model -> outputs equal the model's round-0 lane. Repeat with UNROLL=1, 2, 4; compute latency is 56, 28, 14 cycles.
- Backpressure: out_ready low for 5 cycles at DRAIN word 2 -> out_data stable, no word skipped. Also drive in_valid during UNROLL/DRAIN -> in_ready=0 and no state change.
- Reset mid-UNROLL at rcnt=20 -> next cycle state LOAD, in_ready=1, out_valid=0. A fresh load then completes correctly.
- All-zero lane, LANE=3, ROUNDS=56 -> all-zero output; busy high for exactly 56+4 cycles.
